regbank_reader: RTL and testbench
=================================

# regbank_reader

Read-side sequencer for the 32×32 register bank (`regbank`). On a `start` pulse it walks the bank's two read ports through register pairs (0,1), (2,3), …, (30,31). It captures each pair and presents it on a valid/ready output stream. It sits between the register bank and any downstream consumer (dump/debug/checksum logic), and is the read counterpart to the write-side filling of the bank.

## Interface
Parameters:
- `NUM_REGS`, 32, number of bank registers; must be even, ≥2.
- `DATA_W`, 32, bank word width.
- `ADDR_W`, 5, bank address width; 2^ADDR_W ≥ NUM_REGS.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a full-bank scan; sampled only in IDLE.
- `sr1`  out  ADDR_W  bank read address 1 (even register).
- `sr2`  out  ADDR_W  bank read address 2 (odd register).
- `rd_data1`  in  DATA_W  bank read data for `sr1`; combinational from bank.
- `rd_data2`  in  DATA_W  bank read data for `sr2`.
- `out_data1`  out  DATA_W  captured even-register word.
- `out_data2`  out  DATA_W  captured odd-register word.
- `out_index`  out  ADDR_W-1  pair index p (registers 2p, 2p+1).
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  consumer accepts pair.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- All outputs are registered. Every state and register update occurs on the rising edge of `clk`.
- FSM states: IDLE, READ, SEND, DONE.
- **IDLE**
  - `sr1`=`sr2`=0, `out_valid`=0.
  - When `start`=1: pair counter p←0, `sr1`←0, `sr2`←1, next state READ.
- **READ**
  - Bank addresses are stable for the whole cycle.
  - At the end of the cycle: `out_data1`←`rd_data1`, `out_data2`←`rd_data2`, `out_index`←p, `out_valid`←1, next state SEND.
- **SEND**
  - `out_valid` stays high. Data and index are held stable until the handshake (`out_valid`&`out_ready` at a rising edge).
  - On handshake with p = NUM_REGS/2−1: `out_valid`←0, next state DONE.
  - On handshake otherwise: p←p+1, `sr1`←2(p+1), `sr2`←2(p+1)+1, `out_valid`←0, next state READ.
  - Without handshake: stay in SEND. The bank addresses are not changed.
- **DONE**
  - `done`=1 for exactly one cycle; next state IDLE.
- `start` in any state other than IDLE is ignored. No queuing.
- A bank write that coincides with the READ capture edge: the captured value is the pre-write value, i.e. whatever `rd_data` showed during that cycle. There is no stall and no bypass.
- p never wraps. The scan terminates at the last pair.

## Timing
- Reset (`rst`=1 at an edge), from any state, mid-scan included:
  - state←IDLE, p←0.
  - `sr1`=`sr2`=0, `out_data1`=`out_data2`=0, `out_index`=0.
  - `out_valid`=0, `busy`=0, `done`=0.
  - Reset takes priority over `start` and `out_ready`.
- Let E0 be the edge that samples `start` in IDLE:
  - `busy`=1 after E0.
  - First `out_valid`=1 after E1. Start-to-data latency is 2 cycles.
- Throughput with `out_ready` held high:
  - One pair per 2 cycles. Pair p is accepted at edge E(2p+2).
  - Last pair is accepted at E(NUM_REGS); `done`=1 during the following cycle.
  - IDLE and `busy`=0 after E(NUM_REGS+1).
  - Full default scan: 33 cycles from E0 to IDLE.
- `start` may be reasserted in the cycle after `done`, when the block is in IDLE, and is accepted there.
- Each `out_ready` low cycle in SEND adds exactly one cycle of latency.

## Test plan
- Preload register k with 20·k. Pulse `start` with `out_ready`=1.
  - Required: 16 pairs in order; pair 0 = (0,20), pair 7 = (280,300), pair 15 = (600,620).
  - `out_valid` first high 2 cycles after `start`.
  - `done` pulse at cycle 33; `busy` low after it.
- Backpressure: hold `out_ready`=0 for 5 cycles on pair 3.
  - Required: data (120,140) and `out_index`=3 stable throughout; `sr1`/`sr2` stay 6/7; total scan length +5 cycles.
- Pulse `start` again at pairs 0, 8 and 15 of a running scan.
  - Required: all ignored; a single scan of 16 pairs completes.
- Assert `rst` while in SEND with pair 9 pending.
  - Required: next cycle all outputs 0 and state IDLE. A subsequent `start` rescans from pair 0.
- Write 0xDEADBEEF to register 10 on the same edge that captures pair 5.
  - Required: pair 5 = (200,220). A second scan returns (0xDEADBEEF,220).
- Assert `rst` and `start` together.
  - Required: stays IDLE, `busy`=0. Also issue a back-to-back `start` in the cycle after `done`; required: accepted.

Source files
------------

// File: rtl/regbank_reader.sv
// regbank_reader
// Read-side sequencer for the register bank. A start pulse in IDLE walks the
// bank's two read ports over register pairs (0,1), (2,3), ... and presents
// each captured pair on a valid/ready stream.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a full-bank scan (sampled only in IDLE)
//   sr1, sr2            bank read addresses (even / odd register)
//   rd_data1, rd_data2  combinational bank read data for sr1 / sr2
//   out_data1/2         captured even / odd register words
//   out_index           pair index p (registers 2p, 2p+1)
//   out_valid/ready     output stream handshake
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse after the last pair is accepted
module regbank_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] sr1,
    output logic [ADDR_W-1:0] sr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [ADDR_W-2:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W-2:0] LAST_P = (ADDR_W-1)'(NUM_REGS/2 - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-2:0] p_q, p_d;
    logic [ADDR_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
    logic [DATA_W-1:0] out_data1_q, out_data1_d, out_data2_q, out_data2_d;
    logic [ADDR_W-2:0] out_index_q, out_index_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-2:0] p_inc;

    // p never wraps: the increment is only used when p < LAST_P.
    assign p_inc = p_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = '0;
                    sr1_d   = '0;
                    sr2_d   = ADDR_W'(1);
                    state_d = READ;
                end
            end
            READ: begin
                // Capture whatever the bank shows this cycle; a write landing on
                // the same edge is not seen (no bypass).
                out_data1_d = rd_data1;
                out_data2_d = rd_data2;
                out_index_d = p_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                // Addresses and captured data hold until the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (p_q == LAST_P) begin
                        state_d = DONE;
                    end else begin
                        p_d     = p_inc;
                        sr1_d   = {p_inc, 1'b0};
                        sr2_d   = {p_inc, 1'b1};
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                // Return the bank addresses to 0 as the block re-enters IDLE.
                p_d     = '0;
                sr1_d   = '0;
                sr2_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            out_data1_q <= '0;
            out_data2_q <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sr1       = sr1_q;
    assign sr2       = sr2_q;
    assign out_data1 = out_data1_q;
    assign out_data2 = out_data2_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regbank_reader.sv
// Directed bench for regbank_reader with a small register-bank model.
// Inputs change and outputs are sampled just after the falling edge.
module tb_regbank_reader;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [4:0]  sr1, sr2;
    logic [31:0] rd_data1, rd_data2, out_data1, out_data2;
    logic [3:0]  out_index;
    logic        out_valid, busy, done;

    logic        preload, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] regs [32];

    int n_checks = 0;
    int n_pass   = 0;

    // results of the last do_scan
    int          n_pairs, first_valid, done_at;
    logic        stall_bad, busy_e0, busy_after;
    logic [31:0] got_d1 [16];
    logic [31:0] got_d2 [16];
    logic [3:0]  got_idx [16];

    always #5 clk = ~clk;

    regbank_reader #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .sr1(sr1), .sr2(sr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .out_data1(out_data1), .out_data2(out_data2), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Bank model: combinational reads, writes at the rising edge.
    assign rd_data1 = regs[sr1];
    assign rd_data2 = regs[sr2];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'(20 * k);
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    task automatic do_preload;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    // Runs one scan from a start pulse and records what the stream delivered.
    task automatic do_scan(input int stall_pair, input int stall_len,
                           input logic [31:0] rs_mask, input int wr_pair);
        int scnt;
        logic [31:0] rs_done;
        n_pairs = 0; first_valid = -1; done_at = -1; stall_bad = 1'b0;
        scnt = 0; rs_done = '0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_e0 = busy;
        for (int k = 1; k <= 200 && done_at < 0; k++) begin
            out_ready = 1'b1; start = 1'b0; wr_en = 1'b0;
            if (out_valid) begin
                if (int'(out_index) == stall_pair && scnt < stall_len) begin
                    out_ready = 1'b0;
                    scnt++;
                    if (out_data1 !== 32'(40 * stall_pair) || out_data2 !== 32'(40 * stall_pair + 20) ||
                        sr1 !== 5'(2 * stall_pair) || sr2 !== 5'(2 * stall_pair + 1))
                        stall_bad = 1'b1;
                end else if (n_pairs < 16) begin
                    got_d1[n_pairs] = out_data1;
                    got_d2[n_pairs] = out_data2;
                    got_idx[n_pairs] = out_index;
                    n_pairs++;
                end
                if (rs_mask[out_index] && !rs_done[out_index]) begin
                    start = 1'b1;
                    rs_done[out_index] = 1'b1;
                end
            end
            // The READ cycle of wr_pair: write lands on the capture edge.
            if (wr_pair >= 0 && busy && !out_valid && int'(sr1) == 2 * wr_pair) begin
                wr_en = 1'b1; wr_addr = sr1; wr_data = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = k;
            if (done) done_at = k;
        end
        start = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (sr1 !== 5'd0) $display("FAIL reset_sr1 got %0d exp 0", sr1); else n_pass++;
        n_checks++; if (sr2 !== 5'd0) $display("FAIL reset_sr2 got %0d exp 0", sr2); else n_pass++;
        n_checks++; if (out_data1 !== 32'd0 || out_data2 !== 32'd0)
            $display("FAIL reset_data got %h/%h exp 0/0", out_data1, out_data2); else n_pass++;
        n_checks++; if (out_index !== 4'd0) $display("FAIL reset_index got %0d exp 0", out_index); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_scan;
        int bad;
        do_scan(-1, 0, 32'h0, -1);
        n_checks++; if (busy_e0 !== 1'b1) $display("FAIL full_busy_e0 got %b exp 1", busy_e0); else n_pass++;
        n_checks++; if (first_valid != 1) $display("FAIL full_first_valid got %0d exp 1", first_valid); else n_pass++;
        n_checks++; if (n_pairs != 16) $display("FAIL full_npairs got %0d exp 16", n_pairs); else n_pass++;
        n_checks++; if (got_d1[0] !== 32'd0 || got_d2[0] !== 32'd20)
            $display("FAIL full_pair0 got %0d,%0d exp 0,20", got_d1[0], got_d2[0]); else n_pass++;
        n_checks++; if (got_d1[7] !== 32'd280 || got_d2[7] !== 32'd300)
            $display("FAIL full_pair7 got %0d,%0d exp 280,300", got_d1[7], got_d2[7]); else n_pass++;
        n_checks++; if (got_d1[15] !== 32'd600 || got_d2[15] !== 32'd620)
            $display("FAIL full_pair15 got %0d,%0d exp 600,620", got_d1[15], got_d2[15]); else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) if (got_idx[i] !== 4'(i)) bad++;
        n_checks++; if (bad != 0) $display("FAIL full_index_order got %0d bad exp 0", bad); else n_pass++;
        n_checks++; if (done_at != 32) $display("FAIL full_done_at got %0d exp 32", done_at); else n_pass++;
        n_checks++; if (busy_after !== 1'b0) $display("FAIL full_busy_after got %b exp 0", busy_after); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_scan(3, 5, 32'h0, -1);
        n_checks++; if (stall_bad !== 1'b0) $display("FAIL bp_stable got %b exp 0", stall_bad); else n_pass++;
        n_checks++; if (got_d1[3] !== 32'd120 || got_d2[3] !== 32'd140 || got_idx[3] !== 4'd3)
            $display("FAIL bp_pair3 got %0d,%0d,%0d exp 120,140,3", got_d1[3], got_d2[3], got_idx[3]); else n_pass++;
        n_checks++; if (n_pairs != 16) $display("FAIL bp_npairs got %0d exp 16", n_pairs); else n_pass++;
        n_checks++; if (done_at != 37) $display("FAIL bp_done_at got %0d exp 37", done_at); else n_pass++;
    endtask

    task automatic test_restart_ignored;
        do_scan(-1, 0, 32'h0000_8101, -1);
        n_checks++; if (n_pairs != 16) $display("FAIL rs_npairs got %0d exp 16", n_pairs); else n_pass++;
        n_checks++; if (done_at != 32) $display("FAIL rs_done_at got %0d exp 32", done_at); else n_pass++;
        n_checks++; if (busy_after !== 1'b0) $display("FAIL rs_busy_after got %b exp 0", busy_after); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rs_still_idle got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_mid_reset;
        logic hit;
        hit = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (out_valid && out_index == 4'd9) begin
                hit = 1'b1; out_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++; if (!hit) $display("FAIL mrst_reach_pair9 got 0 exp 1"); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        n_checks++; if (sr1 !== 5'd0 || sr2 !== 5'd0 || out_data1 !== 32'd0 || out_data2 !== 32'd0 ||
                        out_index !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mrst_outputs got sr=%0d/%0d d=%0d/%0d i=%0d v%b b%b d%b exp all 0",
                     sr1, sr2, out_data1, out_data2, out_index, out_valid, busy, done); else n_pass++;
        do_scan(-1, 0, 32'h0, -1);
        n_checks++; if (n_pairs != 16 || got_idx[0] !== 4'd0 || got_d1[0] !== 32'd0 || got_d2[0] !== 32'd20)
            $display("FAIL mrst_rescan got n=%0d i=%0d d=%0d,%0d exp 16,0,0,20",
                     n_pairs, got_idx[0], got_d1[0], got_d2[0]); else n_pass++;
    endtask

    task automatic test_write_collision;
        do_scan(-1, 0, 32'h0, 5);
        n_checks++; if (got_d1[5] !== 32'd200 || got_d2[5] !== 32'd220)
            $display("FAIL wc_first got %h,%h exp c8,dc", got_d1[5], got_d2[5]); else n_pass++;
        do_scan(-1, 0, 32'h0, -1);
        n_checks++; if (got_d1[5] !== 32'hDEADBEEF || got_d2[5] !== 32'd220)
            $display("FAIL wc_second got %h,%h exp deadbeef,dc", got_d1[5], got_d2[5]); else n_pass++;
        do_preload;
    endtask

    task automatic test_rst_start;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rststart_idle got b%b v%b exp b0 v0", busy, out_valid); else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rststart_after got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic seen;
        do_scan(-1, 0, 32'h0, -1);
        // do_scan ends in the cycle after done, with the block in IDLE.
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_idle got b%b d%b exp b0 d0", busy, done); else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accepted got %b exp 1", busy); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL b2b_done got 0 exp 1"); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        preload = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset;
        do_preload;
        test_full_scan;
        test_backpressure;
        test_restart_ignored;
        test_mid_reset;
        test_write_collision;
        test_rst_start;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
